// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter shared by fetch and data access stages
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [LW-1:0]   lat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            owner_d;
    logic            starved;
    logic            grant;
    logic            last_wait;

    assign starved   = (starve_cnt == SW'(STARVE_MAX));
    assign grant     = f_gnt | d_gnt;
    assign last_wait = (state == S_WAIT) && (lat_cnt == LW'(1));

    always_comb begin
        state_nx = state;
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        case (state)
            S_IDLE: begin
                // Data has priority unless fetch has waited out STARVE_MAX data grants
                if (d_req && !(f_req && starved)) begin
                    d_gnt    = 1'b1;
                    state_nx = S_ACCESS;
                end else if (f_req) begin
                    f_gnt    = 1'b1;
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: state_nx = S_WAIT;
            S_WAIT:   if (last_wait) state_nx = S_RESP;
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            m_req <= grant;
            if (grant) begin
                owner_d <= d_gnt;
                m_we    <= d_gnt & d_we;
                m_addr  <= d_gnt ? d_addr : f_addr;
                if (d_gnt) begin
                    m_wdata <= d_wdata;
                end
            end

            if (f_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt) begin
                if (!f_req) begin
                    starve_cnt <= '0;
                end else if (!starved) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end

            if (state == S_ACCESS) begin
                lat_cnt <= LW'(MEM_LAT);
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - LW'(1);
            end

            // Writes complete without touching either read-data register
            if (last_wait && !(owner_d && m_we)) begin
                if (owner_d) begin
                    d_rdata <= m_rdata;
                end else begin
                    f_rdata <= m_rdata;
                end
            end
        end
    end

    assign f_rvalid = (state == S_RESP) && !owner_d;
    assign d_rvalid = (state == S_RESP) && owner_d;
    assign busy     = (state != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single shared single-port memory between the fetch stage (read-only) and the access stage (read/write).
- Replaces separate imem/dmem ports with one unified memory port.
- Non-pipelined: one access in flight, fixed memory read latency MEM_LAT.
- Data-side priority with a starvation guard for fetch. Stage stall logic consumes `busy`, `f_rvalid` and `d_rvalid`.

Parameters:
- MEM_LAT, 2: cycles from the `m_req` cycle to the cycle `m_rdata` is valid; legal range ≥1.
- STARVE_MAX, 3: consecutive data grants allowed while fetch waits before fetch is forced; legal range ≥1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- f_req  input  1  fetch request; held with `f_addr` until `f_gnt`
- f_addr  input  32  fetch address
- f_gnt  output  1  fetch request accepted this cycle (combinational)
- f_rvalid  output  1  one-cycle pulse: `f_rdata` valid
- f_rdata  output  32  fetch read data (registered)
- d_req  input  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_gnt`
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data address
- d_wdata  input  32  write data
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_rvalid  output  1  one-cycle pulse: read data valid, or write complete
- d_rdata  output  32  data read data (registered)
- m_req  output  1  memory access strobe, exactly one cycle per access
- m_we  output  1  memory write enable, qualified by `m_req`
- m_addr  output  32  memory address
- m_wdata  output  32  memory write data
- m_rdata  input  32  memory read data, valid MEM_LAT cycles after the `m_req` cycle
- busy  output  1  state != IDLE

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state = IDLE; lat_cnt = 0; starve_cnt = 0; owner = fetch.
  - All outputs 0, including `f_rdata` and `d_rdata`.
- Reset mid-access: the access is aborted and no `rvalid` pulse is ever issued for it. The requester must re-request after reset release.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Grant is combinational.
  - Only one request asserted → that requester wins.
  - Both asserted → data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Exactly one of `f_gnt`/`d_gnt` pulses for one cycle.
  - At the grant clock edge: latch owner, address, we (fetch forces we = 0), wdata; go to ACCESS.
  - No request → stay in IDLE; all grants 0.
- ACCESS (exactly 1 cycle):
  - `m_req` = 1, with `m_we`/`m_addr`/`m_wdata` from the latched values.
  - lat_cnt ← MEM_LAT; go to WAIT.
  - `m_*` are registered and hold their values outside ACCESS, but `m_req` is 0 outside ACCESS.
- WAIT:
  - lat_cnt decrements each cycle.
  - On the cycle lat_cnt == 1:
    - owner read → capture `m_rdata` into the owner's rdata register;
    - owner write → capture nothing;
    - go to RESP.
- RESP (1 cycle):
  - Owner's `rvalid` = 1.
  - The non-owner's `rdata` is unchanged; for a write, `d_rdata` keeps its prior value.
  - Next state IDLE.
- Timing: grant at cycle 0, `m_req` at cycle 1, `m_rdata` sampled at cycle 1+MEM_LAT, `rvalid` at cycle 2+MEM_LAT.
  - Next grant is possible at cycle 3+MEM_LAT.
  - Sustained throughput: one access per MEM_LAT+3 cycles.
- Starvation counter:
  - Updated at the grant edge only.
  - Data granted while `f_req`=1 → starve_cnt increments, saturating at STARVE_MAX.
  - Fetch granted → starve_cnt ← 0.
  - Data granted while `f_req`=0 → starve_cnt ← 0.
  - Width: clog2(STARVE_MAX+1).
- A request deasserted before its grant is simply dropped; no error is flagged.
- Requests arriving in ACCESS/WAIT/RESP are ignored until IDLE.
- Requester changes to `addr`/`wdata` after the grant have no effect.
- MEM_LAT = 1: WAIT lasts 1 cycle; `rvalid` at cycle 3.
- Address width passes through unmodified; no alignment checks.

Test Plan:
1. MEM_LAT=2. `f_req`=1, `f_addr`=0x100 at cycle 0; memory returns 0xDEADBEEF at cycle 3.
   → `f_gnt`=1 at cycle 0; `m_req`=1, `m_we`=0, `m_addr`=0x100 at cycle 1; `f_rvalid`=1 with `f_rdata`=0xDEADBEEF at cycle 4. `d_rvalid` stays 0 throughout.
2. `d_req`=1, `d_we`=1, `d_addr`=0x200, `d_wdata`=0x12345678.
   → `m_req`=1, `m_we`=1, `m_addr`=0x200, `m_wdata`=0x12345678 for exactly one cycle; `d_rvalid` pulse at cycle 4; `d_rdata` unchanged; `f_rvalid`=0.
3. STARVE_MAX=3. `f_req` and `d_req` held at 1 continuously.
   → grant order D,D,D,F,D,D,D,F. Grants are spaced 5 cycles apart; exactly one grant per IDLE cycle.
4. `f_req` held at 1 for 3 accesses, MEM_LAT=2.
   → `f_gnt` at cycles 0, 5, 10; `busy`=1 on all other cycles from cycle 1 through cycle 14.
5. Assert `rst`=0 asynchronously mid-WAIT of a data read.
   → `m_req`, `busy`, `d_rvalid` go to 0 immediately; `d_rdata`=0. After release, no stale `d_rvalid`; a new fetch is serviced with normal latency.
6. MEM_LAT=1. Fetch read of 0xCAFEF00D at address 0x4.
   → `m_req` at cycle 1, `m_rdata` sampled at cycle 2, `f_rvalid`=1 with `f_rdata`=0xCAFEF00D at cycle 3.
